// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, redirect input and decode handshake.
// Perf counter signals exist only when FETCH_PERF_EN is defined.
interface fetch_unit_if;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        redirect_valid;
    logic [14:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [14:0] out_pc;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
`endif

    modport master (
`ifdef FETCH_PERF_EN
        output perf_fetched,
        output perf_stall,
`endif
        output mem_raddr,
        input  mem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
`ifdef FETCH_PERF_EN
        input  perf_fetched,
        input  perf_stall,
`endif
        input  mem_raddr,
        output mem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited issue, latency tracker, output FIFO.
// Optional FETCH_PERF_EN adds delivered-instruction and stall counters.
module fetch_unit #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          MEM_LATENCY = 2,
    parameter logic [14:0] RESET_PC    = 15'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + MEM_LATENCY + 1);

    typedef struct packed {
        logic [15:0] instr;
        logic [14:0] pc;
    } fifo_ent_t;

    logic [14:0]            pc_q, pc_d;
    logic [MEM_LATENCY-1:0] trk_v_q, trk_v_d;
    logic [14:0]            trk_pc_q [MEM_LATENCY];
    logic [14:0]            trk_pc_d [MEM_LATENCY];
    fifo_ent_t              fifo_q [FIFO_DEPTH];
    fifo_ent_t              head;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          inflight;
    logic                   redir, issue, push, pop, valid;

    function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign redir = bus.redirect_valid;
    assign valid = (cnt_q != '0);
    assign head  = fifo_q[rd_ptr_q];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + CW'(trk_v_q[i]);
        end
    end

    // Same-cycle pops earn no credit, so every tracked return has a slot.
    assign issue = !redir && ((cnt_q + inflight) < CW'(FIFO_DEPTH));
    assign push  = trk_v_q[MEM_LATENCY-1] && !redir;
    assign pop   = valid && bus.out_ready && !redir;

    always_comb begin
        pc_d = pc_q;
        if (redir) begin
            pc_d = bus.redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + 15'd1;
        end
    end

    always_comb begin
        trk_v_d     = '0;
        trk_v_d[0]  = issue;
        trk_pc_d[0] = pc_q;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            trk_v_d[i]  = trk_v_q[i-1] && !redir;
            trk_pc_d[i] = trk_pc_q[i-1];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (redir) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            trk_v_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                trk_pc_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            trk_v_q  <= trk_v_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                trk_pc_q[i] <= trk_pc_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{instr: bus.mem_rdata,
                                  pc:    trk_pc_q[MEM_LATENCY-1]};
        end
    end

    assign bus.mem_raddr = pc_q;
    assign bus.out_valid = valid;
    assign bus.out_instr = valid ? head.instr : '0;
    assign bus.out_pc    = valid ? head.pc : '0;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + (pop ? 16'd1 : 16'd0);
        perf_stall_d   = perf_stall_q + (valid ? 16'd0 : 16'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign bus.perf_fetched = perf_fetched_q;
    assign bus.perf_stall   = perf_stall_q;
`endif
endmodule
